// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline boundary buffers: payload widths per stage
// boundary, field offsets for packing/unpacking, and the pointer wrap helper.
package pipe_pkg;

    localparam int CTRL_W = 16;
    localparam int XLEN   = 32;

    // IFU -> IDU: {inst, pc}
    localparam int IF_ID_PC_LSB   = 0;
    localparam int IF_ID_INST_LSB = IF_ID_PC_LSB + XLEN;
    localparam int IF_ID_W        = IF_ID_INST_LSB + XLEN;

    // IDU -> EXU: {imm, rs2, rs1, pc, ctrl}
    localparam int ID_EX_CTRL_LSB = 0;
    localparam int ID_EX_PC_LSB   = ID_EX_CTRL_LSB + CTRL_W;
    localparam int ID_EX_RS1_LSB  = ID_EX_PC_LSB + XLEN;
    localparam int ID_EX_RS2_LSB  = ID_EX_RS1_LSB + XLEN;
    localparam int ID_EX_IMM_LSB  = ID_EX_RS2_LSB + XLEN;
    localparam int ID_EX_W        = ID_EX_IMM_LSB + XLEN;

    // EXU -> LSU: {store_data, alu_result, pc, ctrl}
    localparam int EX_LS_CTRL_LSB = 0;
    localparam int EX_LS_PC_LSB   = EX_LS_CTRL_LSB + CTRL_W;
    localparam int EX_LS_ALU_LSB  = EX_LS_PC_LSB + XLEN;
    localparam int EX_LS_ST_LSB   = EX_LS_ALU_LSB + XLEN;
    localparam int EX_LS_W        = EX_LS_ST_LSB + XLEN;

    // LSU -> WBU: {wb_data, pc, ctrl}
    localparam int LS_WB_CTRL_LSB = 0;
    localparam int LS_WB_PC_LSB   = LS_WB_CTRL_LSB + CTRL_W;
    localparam int LS_WB_DATA_LSB = LS_WB_PC_LSB + XLEN;
    localparam int LS_WB_W        = LS_WB_DATA_LSB + XLEN;

    // Compare-and-wrap increment so non-power-of-two depths stay in range.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Read/write pointers and occupancy counter for the pipeline stage buffer;
// flush returns everything to zero and overrides push/pop.
module pipe_buf_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = PTR_W'(wrap_inc(int'(wr_ptr_q), DEPTH));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(wrap_inc(int'(rd_ptr_q), DEPTH));
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_ptr = rd_ptr_q;
    assign wr_ptr = wr_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised valid/ready pipeline stage buffer (DEPTH-entry circular store).
// Define PIPE_STAGE_BUF_BYPASS_EN for zero-latency pass-through when empty.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             store;
    logic             bypass_pass;

    // A pop only ever retires a stored entry; a bypassed payload never occupies a slot.
    always_comb begin
        in_ready = !full || out_ready;
        push     = in_valid && in_ready;
        pop      = !empty && out_ready;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
        bypass_pass = empty && in_valid && out_ready && !flush;
        out_valid   = empty ? (in_valid && !flush) : 1'b1;
        out_data    = empty ? in_data : mem_q[rd_ptr];
`else
        bypass_pass = 1'b0;
        out_valid   = !empty;
        out_data    = mem_q[rd_ptr];
`endif
        store = push && !bypass_pass;
    end

    always_comb begin
        mem_d = mem_q;
        if (store && !flush) begin
            mem_d[wr_ptr] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    pipe_buf_ptr #(
        .DEPTH(DEPTH)
    ) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .push  (store),
        .pop   (pop),
        .flush (flush),
        .rd_ptr(rd_ptr),
        .wr_ptr(wr_ptr),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign level = count;

endmodule
